fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of `control`. It owns the program counter and requests 16-bit instructions from instruction memory over a req/ack handshake. It holds each fetched instruction in an instruction register and presents its `op_code`/`func_code` fields to `control`. It then consumes `control`'s `jump`, `halt` and `branch_control` outputs to choose the next PC. It also raises `exc_inst_memory`, which `control` turns into a halt.

---
 rtl/fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
//   Instruction fetch stage placed directly in front of `control`. It holds the
//   program counter, fetches 16-bit instructions over a req/ack handshake and
//   keeps the fetched word in an instruction register (IR). The IR fields go to
//   `control`. The jump/halt/branch decisions that come back from `control`
//   pick the next PC.
//
// Ports
//   clk, rst_n           : single rising-edge clock, async active-low reset
//   imem_req/imem_addr   : fetch request and byte address (address = PC)
//   imem_rdata/ack/err   : returned instruction, data valid, access error
//   jump, halt           : control decisions for the instruction in IR
//   branch_control       : 11 = BLT, 10 = BGT, 01 = BEQ, 00 = none
//   cmp_lt/gt/eq         : op1-vs-op2 comparison from the register file
//   stall                : downstream cannot retire the current instruction
//   op_code, func_code   : IR[15:12], IR[3:0]
//   instruction, pc_out  : IR and the PC it was fetched from
//   inst_valid           : IR holds an instruction being executed (EXEC)
//   exc_inst_memory      : sticky instruction-memory exception
//   halted               : terminal HALTED state reached
// ============================================================================
module fetch_unit #(
   parameter int          ADDR_WIDTH           = 16,
   parameter int          INST_WIDTH           = 16,
   parameter int unsigned MEM_BYTES            = 65536,
   parameter int          BRANCH_CONTROL_WIDTH = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   // instruction memory
   output logic                            imem_req,
   output logic [ADDR_WIDTH-1:0]           imem_addr,
   input  logic [INST_WIDTH-1:0]           imem_rdata,
   input  logic                            imem_ack,
   input  logic                            imem_err,
   // from control / datapath
   input  logic                            jump,
   input  logic                            halt,
   input  logic [BRANCH_CONTROL_WIDTH-1:0] branch_control,
   input  logic                            cmp_lt,
   input  logic                            cmp_gt,
   input  logic                            cmp_eq,
   input  logic                            stall,
   // decode / status
   output logic [3:0]                      op_code,
   output logic [3:0]                      func_code,
   output logic [INST_WIDTH-1:0]           instruction,
   output logic [ADDR_WIDTH-1:0]           pc_out,
   output logic                            inst_valid,
   output logic                            exc_inst_memory,
   output logic                            halted
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_e;

   localparam logic [BRANCH_CONTROL_WIDTH-1:0] BR_BLT = BRANCH_CONTROL_WIDTH'(3);
   localparam logic [BRANCH_CONTROL_WIDTH-1:0] BR_BGT = BRANCH_CONTROL_WIDTH'(2);
   localparam logic [BRANCH_CONTROL_WIDTH-1:0] BR_BEQ = BRANCH_CONTROL_WIDTH'(1);

   // One extra bit so a limit equal to 2^ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

   state_e                  state_q,  state_d;
   logic [ADDR_WIDTH-1:0]   pc_q,     pc_d;
   logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
   logic [INST_WIDTH-1:0]   ir_q,     ir_d;
   logic                    exc_q,    exc_d;

   logic [ADDR_WIDTH-1:0]   pc_seq;
   logic [ADDR_WIDTH-1:0]   pc_jump;
   logic [ADDR_WIDTH-1:0]   br_off;
   logic [ADDR_WIDTH-1:0]   pc_next;
   logic                    br_taken;

   // --------------------------------------------------------------------------
   // Next-PC candidates, all modulo 2^ADDR_WIDTH.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in an always_comb gets a default first so
      // that no path leaves it unassigned, which would infer a latch.
      pc_seq   = pc_q + ADDR_WIDTH'(2);
      // Jump keeps the PC's 8 KiB region (upper bits) and replaces the rest.
      pc_jump  = {pc_q[ADDR_WIDTH-1:13], ir_q[11:0], 1'b0};
      // 4-bit signed halfword offset, sign-extended and scaled to bytes.
      br_off   = {{(ADDR_WIDTH-5){ir_q[3]}}, ir_q[3:0], 1'b0};
      br_taken = ((branch_control == BR_BLT) && cmp_lt) ||
                 ((branch_control == BR_BGT) && cmp_gt) ||
                 ((branch_control == BR_BEQ) && cmp_eq);
      if (jump) begin
         pc_next = pc_jump;
      end else if (br_taken) begin
         pc_next = pc_seq + br_off;
      end else begin
         pc_next = pc_seq;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next-state and register updates.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      ir_d     = ir_q;
      exc_d    = exc_q;

      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end

         FETCH: begin
            if (imem_ack) begin
               if (imem_err) begin
                  exc_d   = 1'b1;
                  state_d = HALTED;
               end else begin
                  ir_d     = imem_rdata;
                  pc_out_d = pc_q;
                  state_d  = EXEC;
               end
            end
         end

         EXEC: begin
            // A stalled instruction is held in place; halt is only honoured
            // once the instruction is actually allowed to retire.
            if (!stall) begin
               if (halt) begin
                  state_d = HALTED;
               end else if ({1'b0, pc_next} >= MEM_LIMIT) begin
                  exc_d   = 1'b1;
                  state_d = HALTED;
               end else begin
                  pc_d    = pc_next;
                  state_d = FETCH;
               end
            end
         end

         HALTED: begin
            // Terminal until reset; all inputs are ignored.
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers.
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   // NOTE: IR and pc_out are ordinary registers (not a memory array) and are
   // reset, since their values are visible on the decode outputs after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         pc_out_q <= '0;
         ir_q     <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         ir_q     <= ir_d;
         exc_q    <= exc_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: decoded purely from registered state, so reset clears them
   // immediately.
   // --------------------------------------------------------------------------
   assign imem_req        = (state_q == FETCH);
   assign imem_addr       = pc_q;
   assign op_code         = ir_q[15:12];
   assign func_code       = ir_q[3:0];
   assign instruction     = ir_q;
   assign pc_out          = pc_out_q;
   assign inst_valid      = (state_q == EXEC);
   assign exc_inst_memory = exc_q;
   assign halted          = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit
//   Directed bench for fetch_unit. Instance `dut` uses the full 64 KiB memory;
//   instance `dut_b` uses a 256-byte memory to exercise the out-of-range
//   redirect exception. Inputs are driven 1 time unit after the rising edge and
//   outputs are sampled at the same point, away from the active edge.
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;

   // main instance
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ack;
   logic        imem_err;
   logic        jump;
   logic        halt;
   logic [1:0]  branch_control;
   logic        cmp_lt;
   logic        cmp_gt;
   logic        cmp_eq;
   logic        stall;
   logic [3:0]  op_code;
   logic [3:0]  func_code;
   logic [15:0] instruction;
   logic [15:0] pc_out;
   logic        inst_valid;
   logic        exc_inst_memory;
   logic        halted;

   // small-memory instance
   logic        b_imem_req;
   logic [15:0] b_imem_addr;
   logic [15:0] b_imem_rdata;
   logic        b_imem_ack;
   logic        b_jump;
   logic        b_zero;
   logic [1:0]  b_branch_control;
   logic [3:0]  b_op_code;
   logic [3:0]  b_func_code;
   logic [15:0] b_instruction;
   logic [15:0] b_pc_out;
   logic        b_inst_valid;
   logic        b_exc_inst_memory;
   logic        b_halted;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_ack        (imem_ack),
      .imem_err        (imem_err),
      .jump            (jump),
      .halt            (halt),
      .branch_control  (branch_control),
      .cmp_lt          (cmp_lt),
      .cmp_gt          (cmp_gt),
      .cmp_eq          (cmp_eq),
      .stall           (stall),
      .op_code         (op_code),
      .func_code       (func_code),
      .instruction     (instruction),
      .pc_out          (pc_out),
      .inst_valid      (inst_valid),
      .exc_inst_memory (exc_inst_memory),
      .halted          (halted)
   );

   fetch_unit #(.MEM_BYTES(256)) dut_b (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (b_imem_req),
      .imem_addr       (b_imem_addr),
      .imem_rdata      (b_imem_rdata),
      .imem_ack        (b_imem_ack),
      .imem_err        (b_zero),
      .jump            (b_jump),
      .halt            (b_zero),
      .branch_control  (b_branch_control),
      .cmp_lt          (b_zero),
      .cmp_gt          (b_zero),
      .cmp_eq          (b_zero),
      .stall           (b_zero),
      .op_code         (b_op_code),
      .func_code       (b_func_code),
      .instruction     (b_instruction),
      .pc_out          (b_pc_out),
      .inst_valid      (b_inst_valid),
      .exc_inst_memory (b_exc_inst_memory),
      .halted          (b_halted)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From FETCH: return `data` with a zero-wait ack, then retire it with the
   // given jump decision. Ends in FETCH of the next address.
   task automatic do_inst(input logic [15:0] data, input logic j);
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
      jump       = j;
      tick();
      jump       = 1'b0;
   endtask

   initial begin
      rst_n            = 1'b0;
      imem_rdata       = '0;
      imem_ack         = 1'b0;
      imem_err         = 1'b0;
      jump             = 1'b0;
      halt             = 1'b0;
      branch_control   = 2'b00;
      cmp_lt           = 1'b0;
      cmp_gt           = 1'b0;
      cmp_eq           = 1'b0;
      stall            = 1'b0;
      b_imem_rdata     = '0;
      b_imem_ack       = 1'b0;
      b_jump           = 1'b0;
      b_zero           = 1'b0;
      b_branch_control = 2'b00;

      // ---------------- reset values ----------------
      #2;
      check("rst_req",        imem_req,        0);
      check("rst_addr",       imem_addr,       0);
      check("rst_instr",      instruction,     0);
      check("rst_op",         op_code,         0);
      check("rst_func",       func_code,       0);
      check("rst_pc_out",     pc_out,          0);
      check("rst_valid",      inst_valid,      0);
      check("rst_exc",        exc_inst_memory, 0);
      check("rst_halted",     halted,          0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle_req",       imem_req,        0);

      // ---------------- sequential fetch, zero wait ----------------
      tick();
      check("f0_req",         imem_req,        1);
      check("f0_addr",        imem_addr,       16'h0000);
      imem_ack   = 1'b1;
      imem_rdata = 16'h0F1F;
      tick();
      imem_ack   = 1'b0;
      check("e0_valid",       inst_valid,      1);
      check("e0_req",         imem_req,        0);
      check("e0_op",          op_code,         0);
      check("e0_func",        func_code,       4'hF);
      check("e0_pc_out",      pc_out,          16'h0000);
      tick();
      check("f1_req",         imem_req,        1);
      check("f1_valid",       inst_valid,      0);
      check("f1_addr",        imem_addr,       16'h0002);
      imem_ack   = 1'b1;
      imem_rdata = 16'h0F2F;
      tick();
      imem_ack   = 1'b0;
      check("e1_valid",       inst_valid,      1);
      check("e1_instr",       instruction,     16'h0F2F);
      check("e1_func",        func_code,       4'hF);
      check("e1_pc_out",      pc_out,          16'h0002);
      tick();
      check("f2_addr",        imem_addr,       16'h0004);

      // ---------------- wait states + stall ----------------
      // First FETCH cycle is the current one; three more with no ack.
      check("ws1_req",        imem_req,        1);
      tick();
      check("ws2_req",        imem_req,        1);
      check("ws2_addr",       imem_addr,       16'h0004);
      tick();
      check("ws3_req",        imem_req,        1);
      check("ws3_addr",       imem_addr,       16'h0004);
      tick();
      check("ws4_req",        imem_req,        1);
      check("ws4_addr",       imem_addr,       16'h0004);
      imem_ack   = 1'b1;
      imem_rdata = 16'h1234;
      tick();
      // Ack stays high with new data during EXEC: must be ignored.
      imem_rdata = 16'hBEEF;
      stall      = 1'b1;
      check("st1_valid",      inst_valid,      1);
      check("st1_op",         op_code,         4'h1);
      check("st1_func",       func_code,       4'h4);
      tick();
      check("st2_valid",      inst_valid,      1);
      check("st2_instr",      instruction,     16'h1234);
      check("st2_addr",       imem_addr,       16'h0004);
      tick();
      stall    = 1'b0;
      imem_ack = 1'b0;
      check("st3_valid",      inst_valid,      1);
      check("st3_instr",      instruction,     16'h1234);
      check("st3_addr",       imem_addr,       16'h0004);
      tick();
      check("st_done_valid",  inst_valid,      0);
      check("st_done_addr",   imem_addr,       16'h0006);

      // ---------------- branches ----------------
      do_inst(16'hC008, 1'b1);                // jump to 0x0010
      check("br_setup_addr",  imem_addr,       16'h0010);
      imem_ack   = 1'b1;
      imem_rdata = 16'h300E;                  // BLT offset -2
      tick();
      imem_ack       = 1'b0;
      branch_control = 2'b11;
      cmp_lt         = 1'b1;
      cmp_gt         = 1'b1;
      check("blt_pc_out",     pc_out,          16'h0010);
      tick();
      check("blt_taken_addr", imem_addr,       16'h000E);
      imem_ack   = 1'b1;
      imem_rdata = 16'h4003;                  // BEQ, not taken
      tick();
      imem_ack       = 1'b0;
      branch_control = 2'b01;
      cmp_eq         = 1'b0;
      tick();
      check("beq_untaken",    imem_addr,       16'h0010);
      imem_ack   = 1'b1;
      imem_rdata = 16'h5002;                  // BGT offset +2
      tick();
      imem_ack       = 1'b0;
      branch_control = 2'b10;
      cmp_lt         = 1'b0;
      tick();
      check("bgt_taken_addr", imem_addr,       16'h0016);
      branch_control = 2'b00;
      cmp_gt         = 1'b0;

      // ---------------- climb to 0x4000 ----------------
      do_inst(16'hCFFF, 1'b1);                // -> 0x1FFE
      do_inst(16'h0000, 1'b0);                // -> 0x2000
      do_inst(16'hCFFF, 1'b1);                // -> 0x3FFE
      do_inst(16'h0000, 1'b0);                // -> 0x4000
      check("climb_addr",     imem_addr,       16'h4000);

      // ---------------- jump priority ----------------
      imem_ack   = 1'b1;
      imem_rdata = 16'hC123;
      tick();
      imem_ack       = 1'b0;
      jump           = 1'b1;
      branch_control = 2'b01;
      cmp_eq         = 1'b1;
      tick();
      jump           = 1'b0;
      branch_control = 2'b00;
      cmp_eq         = 1'b0;
      check("jmp_over_br",    imem_addr,       16'h4246);
      do_inst(16'hC000, 1'b1);                // back to 0x4000
      check("jmp_back_addr",  imem_addr,       16'h4000);
      imem_ack   = 1'b1;
      imem_rdata = 16'hC123;
      tick();
      imem_ack = 1'b0;
      halt     = 1'b1;
      jump     = 1'b1;
      tick();
      halt     = 1'b0;
      jump     = 1'b0;
      check("hlt_halted",     halted,          1);
      check("hlt_exc",        exc_inst_memory, 0);
      check("hlt_req",        imem_req,        0);
      check("hlt_valid",      inst_valid,      0);
      check("hlt_pc",         imem_addr,       16'h4000);
      check("hlt_pc_out",     pc_out,          16'h4000);
      imem_ack   = 1'b1;
      imem_rdata = 16'h7777;
      tick();
      tick();
      imem_ack   = 1'b0;
      check("hlt_sticky",     halted,          1);
      check("hlt_no_req",     imem_req,        0);
      check("hlt_ir_held",    instruction,     16'hC123);

      // ---------------- reset, then climb to 0xFFFE ----------------
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst2_halted",    halted,          0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst2_addr",      imem_addr,       16'h0000);
      for (int k = 0; k < 8; k++) begin
         do_inst(16'hCFFF, 1'b1);
         if (k < 7) do_inst(16'h0000, 1'b0);
      end
      check("wrap_setup",     imem_addr,       16'hFFFE);
      imem_ack   = 1'b1;
      imem_rdata = 16'h0AB7;
      tick();
      imem_ack = 1'b0;
      check("wrap_pc_out",    pc_out,          16'hFFFE);
      tick();
      check("wrap_addr",      imem_addr,       16'h0000);
      check("wrap_no_exc",    exc_inst_memory, 0);
      do_inst(16'h0AB7, 1'b0);
      check("post_wrap_addr", imem_addr,       16'h0002);
      check("post_wrap_ir",   instruction,     16'h0AB7);

      // ---------------- reset mid-fetch ----------------
      check("mf_req_before",  imem_req,        1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mf_req",         imem_req,        0);
      check("mf_addr",        imem_addr,       16'h0000);
      check("mf_instr",       instruction,     16'h0000);
      check("mf_pc_out",      pc_out,          16'h0000);
      check("mf_valid",       inst_valid,      0);
      check("mf_halted",      halted,          0);
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 16'h9999;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mf_idle_req",    imem_req,        0);
      check("mf_ack_ignored", instruction,     16'h0000);
      tick();
      imem_ack = 1'b0;
      check("mf_refetch",     imem_req,        1);

      // ---------------- imem_err exception ----------------
      imem_ack = 1'b1;
      imem_err = 1'b1;
      tick();
      imem_ack = 1'b0;
      imem_err = 1'b0;
      check("err_exc",        exc_inst_memory, 1);
      check("err_halted",     halted,          1);
      check("err_req",        imem_req,        0);
      check("err_ir",         instruction,     16'h0000);
      tick();
      tick();
      check("err_exc_sticky", exc_inst_memory, 1);
      check("err_no_req",     imem_req,        0);

      // ---------------- out-of-range redirect (256-byte memory) ----------------
      check("b_fetch_req",    b_imem_req,      1);
      check("b_fetch_addr",   b_imem_addr,     16'h0000);
      b_imem_ack   = 1'b1;
      b_imem_rdata = 16'hC100;                // jump to 0x0200
      tick();
      b_imem_ack = 1'b0;
      b_jump     = 1'b1;
      check("b_valid",        b_inst_valid,    1);
      tick();
      b_jump = 1'b0;
      check("b_exc",          b_exc_inst_memory, 1);
      check("b_halted",       b_halted,        1);
      check("b_pc_held",      b_imem_addr,     16'h0000);
      check("b_no_req",       b_imem_req,      0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
